// File: rtl/decoder_ctrl_fsm.sv
// Multicycle instruction decoder / controller for the 16-bit CPU.
// Optional conditional branch/jump support is enabled by defining JCOND_EN.
module decoder_ctrl_fsm #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int SEL_W    = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [15:0]         instr,
   input  logic                instr_valid,
   input  logic                cond_true,
   output logic [NUM_REGS-1:0] reg_en,
   output logic [7:0]          alu_op,
   output logic [SEL_W-1:0]    src_a_sel,
   output logic [SEL_W-1:0]    src_b_sel,
   output logic [DATA_W-1:0]   imm,
   output logic                imm_sel,
   output logic                buf_en,
   output logic                flag_en,
   output logic                mem_we,
   output logic                mem_rd,
   output logic                pc_en,
   output logic                pc_mux_sel,
   output logic                illegal,
   output logic                busy
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_NEXT   = 3'd4;

   localparam logic [4:0]          NREG   = 5'(NUM_REGS);
   localparam logic [NUM_REGS-1:0] REG_1H = NUM_REGS'(1);

   logic [2:0]  state_q, state_d;
   logic [15:0] ir_q, ir_d;

   logic [3:0] cls, rdst, ext, rsrc;
   logic [7:0] imm8;
   logic [3:0] op;
   logic       is_r, is_i, is_ld, is_st, is_bc, is_jc;
   logic       zext, is_arith, is_cmp, rdst_bad, rsrc_bad, legal;
   logic [DATA_W-1:0] imm_sx, imm_zx;
   logic [SEL_W-1:0]  rdst_sel, rsrc_sel;

   assign cls  = ir_q[15:12];
   assign rdst = ir_q[11:8];
   assign ext  = ir_q[7:4];
   assign rsrc = ir_q[3:0];
   assign imm8 = ir_q[7:0];

   assign imm_sx   = {{(DATA_W-8){imm8[7]}}, imm8};
   assign imm_zx   = {{(DATA_W-8){1'b0}}, imm8};
   assign rdst_sel = SEL_W'(rdst) + SEL_W'(1);
   assign rsrc_sel = SEL_W'(rsrc) + SEL_W'(1);

`ifndef JCOND_EN
   logic cond_unused;
   assign cond_unused = cond_true;
`endif

   always_comb begin
      is_r  = 1'b0;
      is_i  = 1'b0;
      is_ld = 1'b0;
      is_st = 1'b0;
      is_bc = 1'b0;
      is_jc = 1'b0;
      zext  = 1'b0;
      case (cls)
         4'h0: case (ext)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB: is_r = 1'b1;
            default: ;
         endcase
         4'h8: case (ext)
            4'h0, 4'h4, 4'hC, 4'hF: is_r = 1'b1;
            default: ;
         endcase
         4'h1, 4'h2, 4'h3: begin
            is_i = 1'b1;
            zext = 1'b1;
         end
         4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hD: is_i = 1'b1;
         4'h4: case (ext)
            4'h0: is_ld = 1'b1;
            4'h4: is_st = 1'b1;
`ifdef JCOND_EN
            4'hC: is_jc = 1'b1;
`endif
            default: ;
         endcase
`ifdef JCOND_EN
         4'hC: is_bc = 1'b1;
`endif
         default: ;
      endcase

      // R-type class 0 carries its operation in ext; I-types carry it in class
      op       = (cls == 4'h0) ? ext : cls;
      is_arith = ((is_r && cls == 4'h0) || is_i) &&
                 (op == 4'h5 || op == 4'h6 || op == 4'h7 || op == 4'h9 || op == 4'hB);
      is_cmp   = ((is_r && cls == 4'h0) || is_i) && op == 4'hB;

      rdst_bad = {1'b0, rdst} >= NREG;
      rsrc_bad = {1'b0, rsrc} >= NREG;
      legal    = (is_r || is_i || is_ld || is_st || is_bc || is_jc) &&
                 !((is_r || is_i || is_ld || is_st) && rdst_bad) &&
                 !((is_r || is_ld || is_st || is_jc) && rsrc_bad);
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         S_FETCH: if (instr_valid) begin
            ir_d    = instr;
            state_d = S_DECODE;
         end
         // illegal ops ride through EXEC as a bubble so they keep ALU-op latency
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = (legal && (is_ld || is_st)) ? S_MEM : S_NEXT;
         S_MEM:    state_d = S_NEXT;
         S_NEXT:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      reg_en     = '0;
      alu_op     = '0;
      src_a_sel  = '0;
      src_b_sel  = '0;
      imm        = '0;
      imm_sel    = 1'b0;
      buf_en     = 1'b0;
      flag_en    = 1'b0;
      mem_we     = 1'b0;
      mem_rd     = 1'b0;
      pc_en      = 1'b0;
      pc_mux_sel = 1'b0;
      illegal    = 1'b0;
      busy       = (state_q != S_FETCH);
      case (state_q)
         S_DECODE: illegal = !legal;
         S_EXEC: if (legal) begin
            if (is_r || is_i) begin
               alu_op    = {cls, is_i ? 4'h0 : ext};
               src_a_sel = rdst_sel;
               src_b_sel = is_r ? rsrc_sel : '0;
               imm_sel   = is_i;
               imm       = is_i ? (zext ? imm_zx : imm_sx) : '0;
               buf_en    = 1'b1;
               flag_en   = is_arith;
               if (!is_cmp) reg_en = REG_1H << rdst;
            end else if (is_ld || is_st) begin
               src_b_sel = rsrc_sel;
            end
         end
         S_MEM: begin
            if (is_st) begin
               mem_we    = 1'b1;
               src_a_sel = rdst_sel;
            end
            if (is_ld) begin
               mem_rd = 1'b1;
               reg_en = REG_1H << rdst;
            end
         end
         S_NEXT: begin
            pc_en = 1'b1;
`ifdef JCOND_EN
            if (legal && (is_bc || is_jc)) pc_mux_sel = cond_true;
            if (legal && is_bc) begin
               imm     = imm_sx;
               imm_sel = 1'b1;
            end
            if (legal && is_jc) src_b_sel = rsrc_sel;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_decoder_ctrl_fsm.sv
// Directed table-driven bench for decoder_ctrl_fsm (built with NUM_REGS = 8).
module tb_decoder_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        cond_true;
   logic [7:0]  reg_en;
   logic [7:0]  alu_op;
   logic [4:0]  src_a_sel, src_b_sel;
   logic [15:0] imm;
   logic        imm_sel, buf_en, flag_en, mem_we, mem_rd, pc_en, pc_mux_sel, illegal, busy;

   decoder_ctrl_fsm #(.DATA_W(16), .NUM_REGS(8), .SEL_W(5)) dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .cond_true(cond_true), .reg_en(reg_en), .alu_op(alu_op),
      .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .imm(imm), .imm_sel(imm_sel),
      .buf_en(buf_en), .flag_en(flag_en), .mem_we(mem_we), .mem_rd(mem_rd),
      .pc_en(pc_en), .pc_mux_sel(pc_mux_sel), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  reg_en;
      logic [7:0]  alu_op;
      logic [4:0]  a;
      logic [4:0]  b;
      logic [15:0] imm;
      logic imm_sel, buf_en, flag_en, mem_we, mem_rd, pc_en, pc_mux, illegal, busy;
   } outs_t;

   typedef struct {
      logic [15:0] instr;
      logic        cond;
      logic        is_mem;
      logic        ill;
      outs_t       ex;
      outs_t       mem;
      outs_t       nxt;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;
   vec_t tv[$];

   localparam outs_t IDLE = '{default: '0};
   localparam outs_t BSY  = '{default: '0, busy: 1'b1};
   localparam outs_t NXT  = '{default: '0, pc_en: 1'b1, busy: 1'b1};

   function automatic outs_t snap();
      outs_t s;
      s = '{reg_en: reg_en, alu_op: alu_op, a: src_a_sel, b: src_b_sel, imm: imm,
            imm_sel: imm_sel, buf_en: buf_en, flag_en: flag_en, mem_we: mem_we,
            mem_rd: mem_rd, pc_en: pc_en, pc_mux: pc_mux_sel, illegal: illegal, busy: busy};
      return s;
   endfunction

   task automatic chk(input string name, input int idx, input outs_t exp);
      outs_t act;
      act = snap();
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h required %h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [15:0] i, input logic c, input logic m,
                                input logic il, input outs_t ex, input outs_t mm, input outs_t nx);
      vec_t v;
      v.instr = i; v.cond = c; v.is_mem = m; v.ill = il;
      v.ex = ex; v.mem = mm; v.nxt = nx;
      return v;
   endfunction

   // instr_valid stays high throughout; a different word on instr outside FETCH must be ignored
   task automatic run_vec(input vec_t v, input int idx);
      outs_t dec;
      dec = '{default: '0, illegal: v.ill, busy: 1'b1};
      instr = v.instr; instr_valid = 1'b1; cond_true = v.cond;
      @(posedge clk); #1;
      instr = 16'h4146;
      chk("decode", idx, dec);
      @(posedge clk); #1;
      chk("exec", idx, v.ex);
      if (v.is_mem) begin
         @(posedge clk); #1;
         chk("mem", idx, v.mem);
      end
      @(posedge clk); #1;
      chk("next", idx, v.nxt);
      @(posedge clk); #1;
      chk("fetch", idx, IDLE);
   endtask

   initial begin
      // ALU ops
      tv.push_back(mkv(16'h0354, 0, 0, 0, '{default: '0, reg_en: 8'h08, alu_op: 8'h05, a: 5'd4, b: 5'd5, buf_en: 1, flag_en: 1, busy: 1}, IDLE, NXT));
      tv.push_back(mkv(16'hB2FF, 0, 0, 0, '{default: '0, alu_op: 8'hB0, a: 5'd3, imm: 16'hFFFF, imm_sel: 1, buf_en: 1, flag_en: 1, busy: 1}, IDLE, NXT));
      tv.push_back(mkv(16'h12FF, 0, 0, 0, '{default: '0, reg_en: 8'h04, alu_op: 8'h10, a: 5'd3, imm: 16'h00FF, imm_sel: 1, buf_en: 1, busy: 1}, IDLE, NXT));
      tv.push_back(mkv(16'h23F0, 0, 0, 0, '{default: '0, reg_en: 8'h08, alu_op: 8'h20, a: 5'd4, imm: 16'h00F0, imm_sel: 1, buf_en: 1, busy: 1}, IDLE, NXT));
      tv.push_back(mkv(16'h9380, 0, 0, 0, '{default: '0, reg_en: 8'h08, alu_op: 8'h90, a: 5'd4, imm: 16'hFF80, imm_sel: 1, buf_en: 1, flag_en: 1, busy: 1}, IDLE, NXT));
      tv.push_back(mkv(16'hD180, 0, 0, 0, '{default: '0, reg_en: 8'h02, alu_op: 8'hD0, a: 5'd2, imm: 16'hFF80, imm_sel: 1, buf_en: 1, busy: 1}, IDLE, NXT));
      tv.push_back(mkv(16'h0750, 0, 0, 0, '{default: '0, reg_en: 8'h80, alu_op: 8'h05, a: 5'd8, b: 5'd1, buf_en: 1, flag_en: 1, busy: 1}, IDLE, NXT));
      tv.push_back(mkv(16'h01B2, 0, 0, 0, '{default: '0, alu_op: 8'h0B, a: 5'd2, b: 5'd3, buf_en: 1, flag_en: 1, busy: 1}, IDLE, NXT));
      tv.push_back(mkv(16'h8240, 0, 0, 0, '{default: '0, reg_en: 8'h04, alu_op: 8'h84, a: 5'd3, b: 5'd1, buf_en: 1, busy: 1}, IDLE, NXT));
      tv.push_back(mkv(16'h0641, 0, 0, 0, '{default: '0, reg_en: 8'h40, alu_op: 8'h04, a: 5'd7, b: 5'd2, buf_en: 1, busy: 1}, IDLE, NXT));
      // memory ops
      tv.push_back(mkv(16'h4146, 0, 1, 0, '{default: '0, b: 5'd7, busy: 1}, '{default: '0, mem_we: 1, a: 5'd2, busy: 1}, NXT));
      tv.push_back(mkv(16'h4502, 0, 1, 0, '{default: '0, b: 5'd3, busy: 1}, '{default: '0, mem_rd: 1, reg_en: 8'h20, busy: 1}, NXT));
      // illegal encodings and out-of-range registers
      tv.push_back(mkv(16'hF000, 1, 0, 1, BSY, IDLE, NXT));
      tv.push_back(mkv(16'h0C50, 0, 0, 1, BSY, IDLE, NXT));
      tv.push_back(mkv(16'h0358, 0, 0, 1, BSY, IDLE, NXT));
      tv.push_back(mkv(16'h0300, 0, 0, 1, BSY, IDLE, NXT));
      tv.push_back(mkv(16'h4108, 0, 0, 1, BSY, IDLE, NXT));
      tv.push_back(mkv(16'h4009, 0, 0, 1, BSY, IDLE, NXT));
`ifdef JCOND_EN
      tv.push_back(mkv(16'hC2FE, 1, 0, 0, BSY, IDLE, '{default: '0, pc_en: 1, pc_mux: 1, imm: 16'hFFFE, imm_sel: 1, busy: 1}));
      tv.push_back(mkv(16'hC2FE, 0, 0, 0, BSY, IDLE, '{default: '0, pc_en: 1, imm: 16'hFFFE, imm_sel: 1, busy: 1}));
      tv.push_back(mkv(16'h40C3, 1, 0, 0, BSY, IDLE, '{default: '0, pc_en: 1, pc_mux: 1, b: 5'd4, busy: 1}));
`else
      tv.push_back(mkv(16'hC2FE, 1, 0, 1, BSY, IDLE, NXT));
      tv.push_back(mkv(16'h40C3, 1, 0, 1, BSY, IDLE, NXT));
`endif

      reset = 1'b0; instr = 16'h0354; instr_valid = 1'b1; cond_true = 1'b0;
      #12;
      chk("in_reset", 0, IDLE);
      @(posedge clk); #1;
      reset = 1'b1; instr_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("idle", k, IDLE);
      end

      for (int i = 0; i < tv.size(); i++) run_vec(tv[i], i);

      // reset pulled mid-EXEC: outputs clear without waiting for a clock edge
      instr = 16'h0534; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_exec", 0, '{default: '0, reg_en: 8'h20, alu_op: 8'h03, a: 5'd6, b: 5'd5, buf_en: 1, busy: 1});
      #2 reset = 1'b0;
      #1 chk("async_rst", 0, IDLE);
      @(posedge clk); #1;
      chk("rst_hold", 0, IDLE);
      reset = 1'b1;
      instr = 16'h0354;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("post_rst_idle", k, IDLE);
      end
      run_vec(tv[0], 100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
